// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the three-port DRAM arbiter: FSM states,
// owner encoding and default bus widths.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_RX   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_TX   = 2'd3
    } owner_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/dram_arbiter.sv
// Fixed-priority (rx > cpu > tx) single-port DRAM arbiter: one access at a
// time through IDLE -> ISSUE -> (WAIT) -> ACK with registered outputs.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx_req,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [DATA_W-1:0] rx_wdata,
    output logic              rx_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic [DATA_W-1:0] tx_rdata,
    output logic              tx_ack,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_we,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic              busy
);

    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT);

    state_t           state;
    owner_t           owner;
    logic             we_lat;
    logic [CNT_W-1:0] lat_cnt;

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            we_lat     <= 1'b0;
            lat_cnt    <= '0;
            dram_addr  <= '0;
            dram_wdata <= '0;
            dram_we    <= 1'b0;
            cpu_rdata  <= '0;
            tx_rdata   <= '0;
            rx_ack     <= 1'b0;
            cpu_ack    <= 1'b0;
            tx_ack     <= 1'b0;
        end else begin
            // Strobes default low so each one lives exactly one state.
            dram_we <= 1'b0;
            rx_ack  <= 1'b0;
            cpu_ack <= 1'b0;
            tx_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_req) begin
                        owner      <= OWN_RX;
                        dram_addr  <= rx_addr;
                        dram_wdata <= rx_wdata;
                        we_lat     <= 1'b1;
                        dram_we    <= 1'b1;
                        state      <= ISSUE;
                    end else if (cpu_req) begin
                        owner      <= OWN_CPU;
                        dram_addr  <= cpu_addr;
                        dram_wdata <= cpu_wdata;
                        we_lat     <= cpu_we;
                        dram_we    <= cpu_we;
                        state      <= ISSUE;
                    end else if (tx_req) begin
                        owner     <= OWN_TX;
                        dram_addr <= tx_addr;
                        we_lat    <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_lat) begin
                        rx_ack  <= (owner == OWN_RX);
                        cpu_ack <= (owner == OWN_CPU);
                        tx_ack  <= (owner == OWN_TX);
                        state   <= ACK;
                    end else begin
                        lat_cnt <= CNT_W'(1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // lat_cnt counts DRAM cycles elapsed since the address was issued.
                    if (lat_cnt == LAT_LAST) begin
                        if (owner == OWN_CPU) cpu_rdata <= dram_rdata;
                        if (owner == OWN_TX)  tx_rdata  <= dram_rdata;
                        cpu_ack <= (owner == OWN_CPU);
                        tx_ack  <= (owner == OWN_TX);
                        lat_cnt <= '0;
                        state   <= ACK;
                    end else begin
                        lat_cnt <= lat_cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    owner <= OWN_NONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: stimulus pushes expected DRAM writes and
// acks into queues, a negedge monitor pops and compares them.
module tb_dram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          clock;
    logic          reset_n;
    logic          rx_req, cpu_req, cpu_we, tx_req;
    logic [AW-1:0] rx_addr, cpu_addr, tx_addr;
    logic [DW-1:0] rx_wdata, cpu_wdata;
    logic          rx_ack, cpu_ack, tx_ack, dram_we, busy;
    logic [DW-1:0] cpu_rdata, tx_rdata, dram_wdata, dram_rdata;
    logic [AW-1:0] dram_addr;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .rx_req(rx_req), .rx_addr(rx_addr), .rx_wdata(rx_wdata), .rx_ack(rx_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .tx_req(tx_req), .tx_addr(tx_addr), .tx_rdata(tx_rdata), .tx_ack(tx_ack),
        .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
        .dram_rdata(dram_rdata), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Single-port DRAM with a one-cycle registered read.
    bit [DW-1:0] mem [0:65535];
    always @(posedge clock) begin
        if (dram_we) mem[dram_addr] <= dram_wdata;
        dram_rdata <= mem[dram_addr];
    end

    typedef struct {
        int          src;
        logic [DW-1:0] data;
        int          cyc;
        bit          rd;
    } ack_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    ack_t ackq[$];
    wr_t  wrq[$];
    int   checks = 0;
    int   failures = 0;
    int   tmo = 0;
    bit   chk_rst = 1'b0;
    bit   done = 1'b0;

    function automatic void exp_ack(input int src, input int c, input bit rd, input logic [DW-1:0] d);
        ack_t e;
        e.src = src; e.cyc = c; e.rd = rd; e.data = d;
        ackq.push_back(e);
    endfunction

    function automatic void exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
        wr_t w;
        w.addr = a; w.data = d; w.cyc = c;
        wrq.push_back(w);
    endfunction

    task automatic run_until_done();
        int k;
        k = 0;
        do begin
            @(negedge clock);
            if (rx_ack)  rx_req  = 1'b0;
            if (cpu_ack) cpu_req = 1'b0;
            if (tx_ack)  tx_req  = 1'b0;
            k++;
        end while ((rx_req || cpu_req || tx_req || busy) && k < 60);
        if (k >= 60) tmo++;
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        int   src;
        ack_t e;
        wr_t  w;
        logic [DW-1:0] got;
        forever begin
            @(negedge clock);
            if (chk_rst && !reset_n) begin
                checks++;
                if ({busy, dram_we, rx_ack, cpu_ack, tx_ack, dram_addr, dram_wdata, cpu_rdata, tx_rdata} != '0) begin
                    failures++;
                    $display("FAIL reset_clear: busy=%0b we=%0b acks=%b addr=%h wdata=%h cpu_rd=%h tx_rd=%h, required all 0",
                             busy, dram_we, {rx_ack, cpu_ack, tx_ack}, dram_addr, dram_wdata, cpu_rdata, tx_rdata);
                end
            end
            if (rx_ack || cpu_ack || tx_ack) begin
                checks++;
                if ($countones({rx_ack, cpu_ack, tx_ack}) != 1) begin
                    failures++;
                    $display("FAIL ack_onehot: acks=%b, required one-hot", {rx_ack, cpu_ack, tx_ack});
                end
                src = rx_ack ? 1 : (cpu_ack ? 2 : 3);
                checks++;
                if (ackq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack: src=%0d at cyc=%0d, required no ack", src, cyc);
                end else begin
                    e = ackq.pop_front();
                    if (src != e.src || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL ack_order: src=%0d cyc=%0d, required src=%0d cyc=%0d", src, cyc, e.src, e.cyc);
                    end
                    if (e.rd) begin
                        checks++;
                        got = (src == 2) ? cpu_rdata : tx_rdata;
                        if (got !== e.data) begin
                            failures++;
                            $display("FAIL read_data: src=%0d got=%h, required %h", src, got, e.data);
                        end
                    end
                end
            end
            if (dram_we) begin
                checks++;
                if (wrq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_we: addr=%h data=%h cyc=%0d, required no write", dram_addr, dram_wdata, cyc);
                end else begin
                    w = wrq.pop_front();
                    if (dram_addr !== w.addr || dram_wdata !== w.data || cyc != w.cyc) begin
                        failures++;
                        $display("FAIL dram_write: addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                                 dram_addr, dram_wdata, cyc, w.addr, w.data, w.cyc);
                    end
                end
            end
            if (done) begin
                checks++;
                if (ackq.size() != 0 || wrq.size() != 0 || tmo != 0) begin
                    failures++;
                    $display("FAIL drain: pending_acks=%0d pending_writes=%0d timeouts=%0d, required 0/0/0",
                             ackq.size(), wrq.size(), tmo);
                end
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (cyc > 20000) begin
                failures++;
                $display("FAIL watchdog: cyc=%0d, required completion", cyc);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    // Stimulus
    initial begin : stimulus
        int n;
        rx_req = 0; cpu_req = 0; tx_req = 0; cpu_we = 0;
        rx_addr = '0; cpu_addr = '0; tx_addr = '0; rx_wdata = '0; cpu_wdata = '0;
        reset_n = 1'b1;
        chk_rst = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk_rst = 1'b0;
        @(negedge clock);

        // cpu write 0xA5 -> 0x0010
        n = cyc;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
        exp_wr(16'h0010, 8'hA5, n + 1);
        exp_ack(2, n + 2, 0, '0);
        run_until_done();

        // rx write 0x3C -> 0x0200
        n = cyc;
        rx_req = 1; rx_addr = 16'h0200; rx_wdata = 8'h3C;
        exp_wr(16'h0200, 8'h3C, n + 1);
        exp_ack(1, n + 2, 0, '0);
        run_until_done();

        // tx read 0x0200, three cycles grant-to-ack
        n = cyc;
        tx_req = 1; tx_addr = 16'h0200;
        exp_ack(3, n + 3, 1, 8'h3C);
        run_until_done();

        // cpu read 0x0010
        n = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        exp_ack(2, n + 3, 1, 8'hA5);
        run_until_done();

        // all three at once: served rx, cpu, tx
        n = cyc;
        rx_req = 1; rx_addr = 16'h0300; rx_wdata = 8'h11;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0301; cpu_wdata = 8'h22;
        tx_req = 1; tx_addr = 16'h0301;
        exp_wr(16'h0300, 8'h11, n + 1);
        exp_ack(1, n + 2, 0, '0);
        exp_wr(16'h0301, 8'h22, n + 4);
        exp_ack(2, n + 5, 0, '0);
        exp_ack(3, n + 9, 1, 8'h22);
        run_until_done();

        // cpu read of 0x0300, request dropped and address changed after grant
        n = cyc;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0300;
        exp_ack(2, n + 3, 1, 8'h11);
        @(negedge clock);
        cpu_req = 0; cpu_addr = 16'h0010;
        run_until_done();

        // reset during rx ISSUE: access abandoned, held rx_req re-served afterward
        n = cyc;
        rx_req = 1; rx_addr = 16'h0400; rx_wdata = 8'h77;
        @(posedge clock);
        #2;
        chk_rst = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        chk_rst = 1'b0;
        n = cyc;
        exp_wr(16'h0400, 8'h77, n + 1);
        exp_ack(1, n + 2, 0, '0);
        run_until_done();

        // readback confirms exactly the re-served write landed
        n = cyc;
        tx_req = 1; tx_addr = 16'h0400;
        exp_ack(3, n + 3, 1, 8'h77);
        run_until_done();

        repeat (2) @(negedge clock);
        done = 1'b1;
    end

endmodule
